// File: rtl/aes_gcm_pkg.sv
// Shared GCM definitions: block phase codes, the GHASH reduction constant
// and the finalisation stage FSM encoding. Bit 0 of every 128-bit vector is
// the leftmost bit, i.e. the x^0 coefficient of the field element.
package aes_gcm_pkg;

  // Block type carried alongside every upstream block.
  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_AAD   = 3'd1;
  localparam logic [2:0] PH_TEXT  = 3'd2;
  localparam logic [2:0] PH_FINAL = 3'd3;

  // Reduction constant for x^128 + x^7 + x^2 + x + 1 in reflected bit order.
  localparam logic [0:127] GCM_R = {8'hE1, 120'h0};

  // Finalisation stage FSM.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } ghash_state_t;

endpackage

// File: rtl/gf128_mul_digit.sv
// Digit-serial GF(2^128) multiplier, z = a * b. A start pulse loads the
// operands; DIGIT_BITS multiplier bits are consumed per cycle, and done is
// high in the cycle whose clock edge completes the final digit. z is only
// meaningful while done is high; it is the result of that final digit.
module gf128_mul_digit
  import aes_gcm_pkg::*;
#(
  parameter int DIGIT_BITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] a,
  input  logic [0:127] b,
  output logic         done,
  output logic [0:127] z
);

  localparam int STEPS = 128 / DIGIT_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  logic [0:127]     z_r;
  logic [0:127]     v_r;
  logic [0:127]     a_r;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [0:127]     z_nxt;
  logic [0:127]     v_nxt;

  // One digit of the shift-and-add multiply; a_r[0] is the next bit to use.
  always_comb begin
    z_nxt = z_r;
    v_nxt = v_r;
    for (int j = 0; j < DIGIT_BITS; j++) begin
      if (a_r[j]) begin
        z_nxt = z_nxt ^ v_nxt;
      end
      v_nxt = {1'b0, v_nxt[0:126]} ^ (v_nxt[127] ? GCM_R : 128'h0);
    end
  end

  // Operand, partial product and digit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_r  <= '0;
      v_r  <= '0;
      a_r  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      z_r  <= '0;
      v_r  <= b;
      a_r  <= a;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      z_r <= z_nxt;
      v_r <= v_nxt;
      a_r <= a_r << DIGIT_BITS;
      if (cnt == LAST) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign done = busy && (cnt == LAST);
  assign z    = z_nxt;

endmodule

// File: rtl/aes_ghash_stage.sv
// GCM finalisation stage: XORs plaintext with the keystream block, folds AAD,
// ciphertext and the length block into the GHASH accumulator X, and emits
// tag = X ^ E(K,J0) once the FINAL block has been multiplied in.
//
// Handshake: a block transfers on a rising edge where i_valid && o_ready.
// o_ready depends only on the FSM state (never on i_valid). While o_ready is
// low i_valid is ignored and upstream must hold its block; nothing is
// buffered here. o_ct_valid and o_tag_valid are single-cycle pulses with no
// back-pressure.
module aes_ghash_stage
  import aes_gcm_pkg::*;
#(
  parameter int DIGIT_BITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [0:2]   i_phase,
  input  logic         i_new_instance,
  input  logic [0:127] i_plain_text,
  input  logic [0:127] i_aad,
  input  logic [0:127] i_h,
  input  logic [0:127] i_encrypted_j0,
  input  logic [0:127] i_encrypted_cb,
  input  logic [0:127] i_instance_size,
  output logic         o_ct_valid,
  output logic [0:127] o_cipher_text,
  output logic         o_tag_valid,
  output logic [0:127] o_tag
);

  ghash_state_t state;
  ghash_state_t state_nxt;

  logic         accept;
  logic         ghash_blk;
  logic         mul_start;
  logic         mul_done;
  logic [0:127] ct_c;
  logic [0:127] blk_b;
  logic [0:127] x_eff;
  logic [0:127] h_eff;
  logic [0:127] mul_a;
  logic [0:127] mul_z;
  logic [0:127] x_r;
  logic [0:127] h_r;
  logic [0:127] j0_r;
  logic         final_r;

  assign accept = i_valid && o_ready;
  assign ct_c   = i_plain_text ^ i_encrypted_cb;

  // GHASH operand selection by block type; other phases carry no operand.
  always_comb begin
    blk_b     = '0;
    ghash_blk = 1'b0;
    case (i_phase)
      PH_AAD:   begin blk_b = i_aad;           ghash_blk = 1'b1; end
      PH_TEXT:  begin blk_b = ct_c;            ghash_blk = 1'b1; end
      PH_FINAL: begin blk_b = i_instance_size; ghash_blk = 1'b1; end
      default:  begin blk_b = '0;              ghash_blk = 1'b0; end
    endcase
  end

  // A new instance restarts from X=0 with fresh H, effective for this block.
  assign x_eff     = i_new_instance ? '0 : x_r;
  assign h_eff     = i_new_instance ? i_h : h_r;
  assign mul_a     = x_eff ^ blk_b;
  assign mul_start = accept && ghash_blk;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and ready; in S_IDLE ready is high, so i_valid alone means accept.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid && ghash_blk) begin
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  gf128_mul_digit #(
    .DIGIT_BITS(DIGIT_BITS)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mul_start),
    .a    (mul_a),
    .b    (h_eff),
    .done (mul_done),
    .z    (mul_z)
  );

  // Per-instance context: accumulator, hash subkey, E(K,J0), FINAL marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r     <= '0;
      h_r     <= '0;
      j0_r    <= '0;
      final_r <= 1'b0;
    end else begin
      if (accept && i_new_instance) begin
        x_r  <= '0;
        h_r  <= i_h;
        j0_r <= i_encrypted_j0;
      end
      if (mul_start) begin
        final_r <= (i_phase == PH_FINAL);
      end
      if (mul_done) begin
        x_r <= mul_z;
      end
    end
  end

  // Ciphertext register and its one-cycle qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ct_valid    <= 1'b0;
      o_cipher_text <= '0;
    end else begin
      o_ct_valid <= 1'b0;
      if (accept && (i_phase == PH_TEXT)) begin
        o_cipher_text <= ct_c;
        o_ct_valid    <= 1'b1;
      end
    end
  end

  // Tag register, loaded when the FINAL block's multiply completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tag_valid <= 1'b0;
      o_tag       <= '0;
    end else begin
      o_tag_valid <= 1'b0;
      if (mul_done && final_r) begin
        o_tag       <= mul_z ^ j0_r;
        o_tag_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_ghash_stage.sv
// Self-checking bench for aes_ghash_stage: directed NIST vectors, timing,
// back-pressure and reset-abort cases, then randomized messages compared
// cycle by cycle against a transaction-level GCM model.
module tb_aes_ghash_stage;
  import aes_gcm_pkg::*;

  localparam int MUL_CYC = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- DUT ----------------
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [0:2]   i_phase = 3'd0;
  logic         i_new_instance = 1'b0;
  logic [0:127] i_plain_text = '0;
  logic [0:127] i_aad = '0;
  logic [0:127] i_h = '0;
  logic [0:127] i_encrypted_j0 = '0;
  logic [0:127] i_encrypted_cb = '0;
  logic [0:127] i_instance_size = '0;
  logic         o_ct_valid;
  logic [0:127] o_cipher_text;
  logic         o_tag_valid;
  logic [0:127] o_tag;

  aes_ghash_stage #(.DIGIT_BITS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_phase        (i_phase),
    .i_new_instance (i_new_instance),
    .i_plain_text   (i_plain_text),
    .i_aad          (i_aad),
    .i_h            (i_h),
    .i_encrypted_j0 (i_encrypted_j0),
    .i_encrypted_cb (i_encrypted_cb),
    .i_instance_size(i_instance_size),
    .o_ct_valid     (o_ct_valid),
    .o_cipher_text  (o_cipher_text),
    .o_tag_valid    (o_tag_valid),
    .o_tag          (o_tag)
  );

  // ---------------- check bookkeeping ----------------
  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Full GF(2^128) product, bit by bit, in the reflected bit order of GCM.
  function automatic logic [0:127] gf_mul(logic [0:127] x, logic [0:127] y);
    logic [0:127] z;
    logic [0:127] v;
    logic [0:127] r;
    z = '0;
    v = y;
    r = {8'he1, 120'd0};
    for (int i = 0; i < 128; i++) begin
      if (x[i]) z = z ^ v;
      v = v[127] ? ((v >> 1) ^ r) : (v >> 1);
    end
    return z;
  endfunction

  // ---------------- behavioural model ----------------
  // Per accepted block: apply new-instance context, fold the block into X at
  // once, and schedule the tag to appear MUL_CYC edges later.
  logic         m_ready = 1'b1;
  logic         m_ct_v  = 1'b0;
  logic         m_tag_v = 1'b0;
  logic [0:127] m_ct  = '0;
  logic [0:127] m_tag = '0;
  logic [0:127] m_x   = '0;
  logic [0:127] m_h   = '0;
  logic [0:127] m_j0  = '0;
  int           m_busy = 0;
  logic [127:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    logic         acc;
    logic         gh;
    logic [0:127] b;
    if (!rst_n) begin
      m_ready = 1'b1; m_ct_v = 1'b0; m_tag_v = 1'b0;
      m_ct = '0; m_tag = '0; m_x = '0; m_h = '0; m_j0 = '0;
      m_busy = 0;
      exp_q.delete();
    end else begin
      acc     = i_valid && m_ready;
      m_ct_v  = 1'b0;
      m_tag_v = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0 && exp_q.size() > 0) begin
          m_tag   = exp_q.pop_front();
          m_tag_v = 1'b1;
        end
      end
      if (acc) begin
        if (i_new_instance) begin
          m_x = '0; m_h = i_h; m_j0 = i_encrypted_j0;
        end
        gh = 1'b1;
        b  = '0;
        case (i_phase)
          3'd1: b = i_aad;
          3'd2: begin b = i_plain_text ^ i_encrypted_cb; m_ct = b; m_ct_v = 1'b1; end
          3'd3: b = i_instance_size;
          default: gh = 1'b0;
        endcase
        if (gh) begin
          m_x    = gf_mul(m_x ^ b, m_h);
          m_busy = MUL_CYC;
          if (i_phase == 3'd3) exp_q.push_back(m_x ^ m_j0);
        end
      end
      m_ready = (m_busy == 0);
    end
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("ready", {127'd0, o_ready}, {127'd0, m_ready});
    chk("ct_valid", {127'd0, o_ct_valid}, {127'd0, m_ct_v});
    chk("tag_valid", {127'd0, o_tag_valid}, {127'd0, m_tag_v});
    chk("cipher_text", o_cipher_text, m_ct);
    chk("tag", o_tag, m_tag);
  end

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic send(input logic [2:0] ph, input logic ni, input logic [127:0] pt,
                      input logic [127:0] cb, input logic [127:0] aad,
                      input logic [127:0] h, input logic [127:0] j0,
                      input logic [127:0] sz, output int acc_edge);
    logic rdy;
    int   waited;
    waited = 0;
    i_phase = ph; i_new_instance = ni; i_plain_text = pt; i_encrypted_cb = cb;
    i_aad = aad; i_h = h; i_encrypted_j0 = j0; i_instance_size = sz;
    i_valid = 1'b1;
    acc_edge = -1;
    while (acc_edge < 0) begin
      rdy = o_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        acc_edge = edge_cnt;
      end else begin
        waited++;
        if (waited > 100) begin
          n_chk++; n_err++;
          $display("FAIL accept_timeout: block not accepted within 100 cycles");
          acc_edge = 0;
        end
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tag(input int limit, output logic [127:0] tag, output int at_edge);
    at_edge = -1;
    tag     = '0;
    for (int k = 0; k < limit && at_edge < 0; k++) begin
      if (o_tag_valid) begin
        tag = o_tag; at_edge = edge_cnt;
      end else begin
        @(negedge clk);
      end
    end
    if (at_edge < 0) begin
      n_chk++; n_err++;
      $display("FAIL tag_timeout: no tag within %0d cycles", limit);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  localparam logic [127:0] TC_H  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] TC_J0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] TC_CB = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] TC2_T = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] ID_H  = 128'h80000000000000000000000000000000;
  localparam logic [127:0] ID_A  = 128'h0123456789abcdef0011223344556677;

  initial begin
    int           a0, a1, te, pulses;
    logic [127:0] tg, j0r, x1;

    // Reset held for 3 cycles: all outputs zero, ready high.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {127'd0, o_ready}, 128'd1);
    chk("rst_ct_valid", {127'd0, o_ct_valid}, 128'd0);
    chk("rst_tag_valid", {127'd0, o_tag_valid}, 128'd0);
    chk("rst_cipher_text", o_cipher_text, 128'd0);
    chk("rst_tag", o_tag, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pin the model against hand-known results.
    chk("model_identity", gf_mul(ID_A, ID_H), ID_A);
    x1 = gf_mul(TC_CB, TC_H);
    chk("model_tc2_tag", gf_mul(x1 ^ 128'h80, TC_H) ^ TC_J0, TC2_T);

    // NIST TC1: empty message, tag = E(K,J0), 16 edges after accept.
    send(PH_FINAL, 1'b1, '0, '0, '0, TC_H, TC_J0, '0, a0);
    wait_tag(40, tg, te);
    chk("tc1_tag", tg, TC_J0);
    chk("tc1_tag_latency", 128'(te - a0), 128'(MUL_CYC));
    @(negedge clk);
    chk("tc1_tag_pulse_width", {127'd0, o_tag_valid}, 128'd0);

    // NIST TC2: one zero plaintext block, then the length block. The FINAL
    // block is presented immediately and must wait out the multiply.
    send(PH_TEXT, 1'b1, '0, TC_CB, '0, TC_H, TC_J0, '0, a0);
    chk("tc2_ct_valid", {127'd0, o_ct_valid}, 128'd1);
    chk("tc2_cipher_text", o_cipher_text, TC_CB);
    send(PH_FINAL, 1'b0, '0, '0, '0, '0, '0, 128'h80, a1);
    chk("backpressure_accept_gap", 128'(a1 - a0), 128'(MUL_CYC + 1));
    wait_tag(40, tg, te);
    chk("tc2_tag", tg, TC2_T);

    // Identity H: tag reduces to AAD ^ J0.
    j0r = rand128();
    send(PH_AAD, 1'b1, rand128(), rand128(), ID_A, ID_H, j0r, rand128(), a0);
    send(PH_FINAL, 1'b0, '0, '0, '0, '0, '0, '0, a1);
    wait_tag(40, tg, te);
    chk("identity_tag", tg, ID_A ^ j0r);

    // Non-GHASH phases are accepted back to back.
    send(PH_IDLE, 1'b0, rand128(), rand128(), rand128(), rand128(), rand128(), rand128(), a0);
    send(3'd5, 1'b0, rand128(), rand128(), rand128(), rand128(), rand128(), rand128(), a1);
    chk("idle_back_to_back", 128'(a1 - a0), 128'd1);
    send(3'd7, 1'b0, rand128(), rand128(), rand128(), rand128(), rand128(), rand128(), a0);
    chk("idle_after_idle", 128'(a0 - a1), 128'd1);

    // Reset at E8 of a FINAL multiply: no tag afterwards, ready at once.
    send(PH_FINAL, 1'b1, '0, '0, '0, TC_H, TC_J0, '0, a0);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready_in_reset", {127'd0, o_ready}, 128'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready_after_release", {127'd0, o_ready}, 128'd1);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_tag_valid) pulses++;
    end
    chk("abort_no_tag", 128'(pulses), 128'd0);

    // Randomized messages against the model.
    for (int m = 0; m < 15; m++) begin
      int   n_aad, n_txt;
      logic first;
      logic [127:0] h, j0;
      n_aad = $urandom_range(0, 2);
      n_txt = $urandom_range(0, 3);
      h     = rand128();
      j0    = rand128();
      first = 1'b1;
      for (int k = 0; k < n_aad + n_txt; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          send(($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(4, 7)), first,
               rand128(), rand128(), rand128(), h, j0, rand128(), a0);
        end
        send((k < n_aad) ? PH_AAD : PH_TEXT, first, rand128(), rand128(), rand128(),
             h, j0, rand128(), a0);
        first = 1'b0;
        idle($urandom_range(0, 3));
      end
      send(PH_FINAL, first, rand128(), rand128(), rand128(), h, j0,
           {64'(n_aad * 128), 64'(n_txt * 128)}, a0);
      wait_tag(40, tg, te);
      idle($urandom_range(0, 2));
    end

    idle(20);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_ghash_stage.md
# aes_ghash_stage

GCM finalisation stage directly downstream of the last AES round stage. It consumes the fully encrypted counter block, E(K,J0) and H produced by the AES pipeline. It XORs plaintext with the keystream to emit ciphertext, and accumulates GHASH over AAD, ciphertext and the length block using a digit-serial GF(2^128) multiplier. It emits the authentication tag at the end of each instance.

## Interface
Parameters:
- `DIGIT_BITS`, default 8: multiplier bits per cycle; must divide 128. Multiply latency is 128/DIGIT_BITS cycles (16 by default).

Ports (all vectors `[0:N-1]`, bit 0 = leftmost / x^0 coefficient per SP 800-38D):
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: upstream block present.
- `o_ready` out 1: stage can accept a block this cycle.
- `i_phase` in 3: block type.
- `i_new_instance` in 1: first block of a new message.
- `i_plain_text` in 128: plaintext block.
- `i_aad` in 128: AAD block.
- `i_h` in 128: hash subkey E(K,0^128).
- `i_encrypted_j0` in 128: E(K,J0).
- `i_encrypted_cb` in 128: E(K,CB), the keystream block.
- `i_instance_size` in 128: len(A)||len(C) block, in bits.
- `o_ct_valid` out 1: one-cycle pulse qualifying `o_cipher_text`.
- `o_cipher_text` out 128: ciphertext block.
- `o_tag_valid` out 1: one-cycle pulse qualifying `o_tag`.
- `o_tag` out 128: authentication tag.

## Operation
- Accept when `i_valid && o_ready` at a rising edge. The accepting edge is E0.
- If `i_new_instance` is set at accept:
  - X (GHASH accumulator) clears to 0.
  - H_r is loaded with `i_h`.
  - J0_r is loaded with `i_encrypted_j0`.
  - These take effect before this block's XOR.
- GHASH operand B is selected by `i_phase`:
  - PH_AAD (3'd1): B = `i_aad`.
  - PH_TEXT (3'd2): B = C = `i_plain_text ^ i_encrypted_cb`. C is registered into `o_cipher_text` at E0, and `o_ct_valid` is high for the following cycle.
  - PH_FINAL (3'd3): B = `i_instance_size`.
  - PH_IDLE (3'd0) and 3'd4–3'd7: the block is consumed with no GHASH update and no outputs. `i_new_instance` handling still applies.
- For AAD, TEXT and FINAL, the FSM enters S_MUL with the operand X^B. Y = H_r.
- Multiply algorithm (SP 800-38D Alg. 1): Z=0, V=Y; for i=0..127: if operand[i] then Z^=V; V = (V>>1) ^ (V[127] ? R : 0), with R = 0xE1 followed by 120 zero bits.
- DIGIT_BITS iterations run per cycle.
- On completion X becomes Z.
- FSM:
  - S_IDLE: `o_ready`=1. Transitions to S_MUL on a GHASH-bearing accept; otherwise stays.
  - S_MUL: `o_ready`=0. A digit counter runs 0..(128/DIGIT_BITS−1). On the final count it returns to S_IDLE, and if the block was FINAL it loads the tag.
- Tag = X_final ^ J0_r. `o_tag_valid` pulses for one cycle. X is not cleared until the next `i_new_instance`.
- `i_valid` is ignored while `o_ready`=0. Upstream must hold its block; this stage does not buffer.

## Timing
- Reset values: `o_ready`=1, `o_ct_valid`=0, `o_tag_valid`=0, `o_cipher_text`=0, `o_tag`=0. X, H_r, J0_r, counter and FSM clear to 0 / S_IDLE.
- Ciphertext latency: `o_ct_valid` is high in the cycle after E0.
- Multiply: with DIGIT_BITS=8, the FSM is in S_MUL for cycles after E0..E15 and returns to S_IDLE at E16. The next accept is possible at E17. Throughput is one GHASH block per 17 cycles.
- PH_IDLE blocks are accepted back-to-back, one per cycle.
- Tag: for a FINAL block accepted at E0, `o_tag` is loaded and `o_tag_valid` rises at E16. It is high for exactly one cycle.
- `rst_n` asserted mid-multiply aborts the operation immediately:
  - no tag is produced;
  - after release the stage is in S_IDLE with `o_ready`=1.
- A `new_instance` arriving with PH_FINAL is legal (empty A and C). X=0, so the tag equals E(K,J0) when the length block is zero.

## Structure
- Shared package `aes_gcm_pkg`:
  - phase constants PH_IDLE/PH_AAD/PH_TEXT/PH_FINAL (3-bit);
  - GCM reduction constant R;
  - FSM enum.
  - All pipeline stages import the phase constants from this package.
- Sub-module `gf128_mul_digit`:
  - holds Z, V and operand registers and the digit counter;
  - interface `start`, `a`, `b`, `done`, `z`.
- The top level holds the FSM, the XOR datapath and the tag logic.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → all outputs 0, `o_ready`=1.
- NIST TC1 (K=0, IV=0, empty):
  - stimulus: FINAL+`new_instance`, `i_instance_size`=0, `i_h`=66e94bd4ef8a2c3b884cfa59ca342b2e, `i_encrypted_j0`=58e2fccefa7e3061367f1d57a4e7455a.
  - expected: `o_tag`=58e2fccefa7e3061367f1d57a4e7455a, valid at E16.
- NIST TC2 (P=0^128), step 1:
  - stimulus: TEXT+`new_instance`, `i_encrypted_cb`=0388dace60b6a392f328c2b971b2fe78.
  - expected: `o_cipher_text`=0388dace60b6a392f328c2b971b2fe78 at E0+1.
- NIST TC2, step 2:
  - stimulus: FINAL, len block=0…080.
  - expected: `o_tag`=ab6e47d42cec13bdf53a67b21257bddf.
- Identity multiply:
  - stimulus: H=80000000000000000000000000000000, AAD=0123456789abcdef0011223344556677, then FINAL with len=0.
  - expected: tag = (0123…6677 · H) ^ J0 = 0123456789abcdef0011223344556677 ^ J0.
- Backpressure and reset:
  - stimulus: `i_valid` held high during S_MUL; a second block waits until E17. Assert `rst_n` at E8 of a FINAL multiply.
  - expected: the second block is not accepted early. After the reset, no `o_tag_valid` pulse occurs and `o_ready`=1 immediately.
